// File: rtl/ysyx_22040895_immgen_pipe.sv
// RISC-V immediate generator with a 1-cycle output register and a skid register.
// Accepts one beat per cycle; in_ready_o is registered, so the first stalled beat lands in the skid slot.
module ysyx_22040895_immgen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_inst_i,
    input  logic [2:0]       in_fmt_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_imm_o,
    output logic [TAG_W-1:0] out_tag_o
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("ysyx_22040895_immgen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_Z  = 3'd6;
    localparam logic [2:0] FMT_SH = 3'd7;

    logic [XLEN-1:0]  asm_imm;
    logic             in_xfer;
    logic             out_xfer;

    logic             m_vld_q, m_vld_d;
    logic [XLEN-1:0]  m_imm_q, m_imm_d;
    logic [TAG_W-1:0] m_tag_q, m_tag_d;
    logic             k_vld_q, k_vld_d;
    logic [XLEN-1:0]  k_imm_q, k_imm_d;
    logic [TAG_W-1:0] k_tag_q, k_tag_d;

    // The opcode field is decoded elsewhere; the format select replaces it here.
    logic unused_opcode;
    assign unused_opcode = ^in_inst_i[6:0];

    always_comb begin
        asm_imm = '0;
        case (in_fmt_i)
            FMT_I: begin
                asm_imm        = {XLEN{in_inst_i[31]}};
                asm_imm[11:0]  = in_inst_i[31:20];
            end
            FMT_S: begin
                asm_imm        = {XLEN{in_inst_i[31]}};
                asm_imm[11:0]  = {in_inst_i[31:25], in_inst_i[11:7]};
            end
            FMT_B: begin
                asm_imm        = {XLEN{in_inst_i[31]}};
                asm_imm[12:0]  = {in_inst_i[31], in_inst_i[7], in_inst_i[30:25],
                                  in_inst_i[11:8], 1'b0};
            end
            FMT_U: begin
                asm_imm        = {XLEN{in_inst_i[31]}};
                asm_imm[31:0]  = {in_inst_i[31:12], 12'b0};
            end
            FMT_J: begin
                asm_imm        = {XLEN{in_inst_i[31]}};
                asm_imm[20:0]  = {in_inst_i[31], in_inst_i[19:12], in_inst_i[20],
                                  in_inst_i[30:21], 1'b0};
            end
            FMT_Z: asm_imm[4:0] = in_inst_i[19:15];
            FMT_SH: begin
                if (XLEN == 64) asm_imm[5:0] = in_inst_i[25:20];
                else            asm_imm[4:0] = in_inst_i[24:20];
            end
            default: asm_imm = '0;
        endcase
    end

    assign in_ready_o  = rst & ~k_vld_q;
    assign in_xfer     = in_valid_i & in_ready_o;
    assign out_valid_o = m_vld_q;
    assign out_xfer    = m_vld_q & out_ready_i;
    assign out_imm_o   = m_vld_q ? m_imm_q : '0;
    assign out_tag_o   = m_vld_q ? m_tag_q : '0;

    always_comb begin
        m_vld_d = m_vld_q;
        m_imm_d = m_imm_q;
        m_tag_d = m_tag_q;
        k_vld_d = k_vld_q;
        k_imm_d = k_imm_q;
        k_tag_d = k_tag_q;
        if (flush_i) begin
            m_vld_d = 1'b0;
            k_vld_d = 1'b0;
        end else if (k_vld_q) begin
            // Skid occupied: in_ready_o is low, so only the K->M move can happen.
            if (out_xfer) begin
                m_imm_d = k_imm_q;
                m_tag_d = k_tag_q;
                k_vld_d = 1'b0;
            end
        end else if (!m_vld_q || out_xfer) begin
            m_vld_d = in_xfer;
            if (in_xfer) begin
                m_imm_d = asm_imm;
                m_tag_d = in_tag_i;
            end
        end else if (in_xfer) begin
            k_vld_d = 1'b1;
            k_imm_d = asm_imm;
            k_tag_d = in_tag_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_vld_q <= 1'b0;
            m_imm_q <= '0;
            m_tag_q <= '0;
            k_vld_q <= 1'b0;
            k_imm_q <= '0;
            k_tag_q <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            m_imm_q <= m_imm_d;
            m_tag_q <= m_tag_d;
            k_vld_q <= k_vld_d;
            k_imm_q <= k_imm_d;
            k_tag_q <= k_tag_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22040895_immgen_pipe.sv
// Bench for the immediate generator: directed vectors, back-pressure, flush, async reset, random traffic.
module tb_ysyx_22040895_immgen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [63:0] tag;
    logic        out_ready;

    logic        in_ready64, out_valid64;
    logic [63:0] out_imm64, out_tag64;
    logic        in_ready32, out_valid32;
    logic [31:0] out_imm32;
    logic [63:0] out_tag32;

    int n_chk  = 0;
    int n_fail = 0;
    int n_out  = 0;
    bit last_ix;

    typedef struct {
        logic [63:0] i64;
        logic [31:0] i32;
        logic [63:0] tg;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    ysyx_22040895_immgen_pipe #(.XLEN(64), .TAG_W(64)) u_dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready64),
        .in_inst_i(inst), .in_fmt_i(fmt), .in_tag_i(tag),
        .out_valid_o(out_valid64), .out_ready_i(out_ready),
        .out_imm_o(out_imm64), .out_tag_o(out_tag64)
    );

    ysyx_22040895_immgen_pipe #(.XLEN(32), .TAG_W(64)) u_dut32 (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready32),
        .in_inst_i(inst), .in_fmt_i(fmt), .in_tag_i(tag),
        .out_valid_o(out_valid32), .out_ready_i(out_ready),
        .out_imm_o(out_imm32), .out_tag_o(out_tag32)
    );

    // Reference: pick the field as an unsigned number, then sign-extend arithmetically.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] f, input int xlen);
        longint raw;
        longint v;
        int     nb;
        raw = 0;
        nb  = 0;
        case (f)
            3'd1: begin raw = longint'(ins[31:20]); nb = 12; end
            3'd2: begin raw = longint'({ins[31:25], ins[11:7]}); nb = 12; end
            3'd3: begin raw = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); nb = 13; end
            3'd4: begin raw = longint'(ins[31:12]) * 4096; nb = 32; end
            3'd5: begin raw = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); nb = 21; end
            3'd6: return 64'(ins[19:15]);
            3'd7: return (xlen == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
            default: return 64'd0;
        endcase
        v = (raw >= (64'sd1 <<< (nb - 1))) ? raw - (64'sd1 <<< nb) : raw;
        if (xlen == 32) v = v & 64'sh0000_0000_FFFF_FFFF;
        return 64'(v);
    endfunction

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 64'(out_valid64), 64'(mq.size() > 0));
        check("in_ready", 64'(in_ready64), 64'(mq.size() < 2));
        check("in_ready32", 64'(in_ready32), 64'(mq.size() < 2));
        if (mq.size() > 0) begin
            check("out_imm", out_imm64, mq[0].i64);
            check("out_tag", out_tag64, mq[0].tg);
            check("out_imm32", 64'(out_imm32), 64'(mq[0].i32));
        end else begin
            check("idle_imm", out_imm64, 64'd0);
            check("idle_tag", out_tag64, 64'd0);
        end
    endtask

    // Check, then advance one edge while updating the scoreboard.
    task automatic tick();
        bit          ix, ox;
        ent_t        e;
        logic [63:0] r32;
        #1;
        check_outputs();
        ix = in_valid && (mq.size() < 2);
        ox = out_ready && (mq.size() > 0);
        e.i64 = ref_imm(inst, fmt, 64);
        r32   = ref_imm(inst, fmt, 32);
        e.i32 = r32[31:0];
        e.tg  = tag;
        @(posedge clk);
        if (ox) begin
            void'(mq.pop_front());
            n_out++;
        end
        if (flush) mq.delete();
        else if (ix) mq.push_back(e);
        last_ix = ix && !flush;
        #1;
    endtask

    task automatic send_expect(input string nm, input logic [31:0] i, input logic [2:0] f,
                               input logic [63:0] t, input logic [63:0] e64, input logic [31:0] e32);
        inst = i; fmt = f; tag = t; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        check({nm, "_imm64"}, out_imm64, e64);
        check({nm, "_imm32"}, 64'(out_imm32), 64'(e32));
        check({nm, "_tag"}, out_tag64, t);
        tick();
    endtask

    initial begin
        int base;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; inst = '0; fmt = '0; tag = '0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid64), 64'd0);
        check("rst_out_imm", out_imm64, 64'd0);
        check("rst_in_ready", 64'(in_ready64), 64'd0);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready64), 64'd1);
        check("post_rst_out_valid", 64'(out_valid64), 64'd0);

        send_expect("I",  32'hFFF00093, 3'd1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
        send_expect("B",  32'hFE000EE3, 3'd3, 64'h8000_0004, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC);
        send_expect("U",  32'h800000B7, 3'd4, 64'h8000_0008, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000);
        send_expect("SH", 32'h03F0D093, 3'd7, 64'h8000_000C, 64'h0000_0000_0000_003F, 32'h0000_001F);

        // Back-pressure: A into M, B into K, C held.
        out_ready = 1'b0; fmt = 3'd1; in_valid = 1'b1;
        inst = 32'h0010_0093; tag = 64'hA; tick();
        inst = 32'h0020_0093; tag = 64'hB; tick();
        inst = 32'h0030_0093; tag = 64'hC; tick();
        check("bp_in_ready_low", 64'(in_ready64), 64'd0);
        check("bp_head_tag", out_tag64, 64'hA);
        tick();
        base = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_ix) break;
        end
        check("bp_c_accepted", 64'(last_ix), 64'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("bp_emitted_once_each", 64'(n_out - base), 64'd3);

        // Flush with M and K full and a valid input pending.
        out_ready = 1'b0; in_valid = 1'b1;
        tag = 64'h10; tick();
        tag = 64'h11; tick();
        tag = 64'h12; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid64), 64'd0);
        check("flush_in_ready", 64'(in_ready64), 64'd1);
        base = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("flush_nothing_emitted", 64'(n_out - base), 64'd0);

        // Asynchronous reset between edges with a beat held in M.
        out_ready = 1'b0; in_valid = 1'b1; inst = 32'hFFF00093; fmt = 3'd1; tag = 64'h55;
        tick();
        in_valid = 1'b0;
        #2;
        check("arst_pre_valid", 64'(out_valid64), 64'd1);
        rst = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid64), 64'd0);
        check("arst_out_imm", out_imm64, 64'd0);
        check("arst_in_ready", 64'(in_ready64), 64'd0);
        mq.delete();
        #3;
        rst = 1'b1;
        #1;
        check("arst_release_in_ready", 64'(in_ready64), 64'd1);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            inst      = $urandom;
            fmt       = 3'($urandom_range(0, 7));
            tag       = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("drain_empty", 64'(out_valid64), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040895_immgen_pipe.md
# ysyx_22040895_immgen_pipe

Pipelined, parametrised immediate generator for the decode stage. It takes a 32-bit RISC-V instruction plus a format select and produces the immediate extended to XLEN bits: sign-extended for I/S/B/U/J, zero-extended for CSR zimm and shift amounts. A valid/ready handshake on both sides and a 2-entry skid buffer let it sit between the fetch/decode boundary and the issue logic at full throughput under back-pressure.

## Interface

Parameters:
- `XLEN`, 64, output immediate width; only 32 and 64 are legal.
- `TAG_W`, 64, width of the sideband tag (normally the PC), carried unchanged alongside the immediate.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  synchronous drop of all buffered entries.
- `in_valid_i`  in  1  upstream beat valid.
- `in_ready_o`  out  1  block can accept a beat.
- `in_inst_i`  in  32  raw instruction.
- `in_fmt_i`  in  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 SH (shamt).
- `in_tag_i`  in  TAG_W  sideband tag.
- `out_valid_o`  out  1  downstream beat valid.
- `out_ready_i`  in  1  downstream accepts.
- `out_imm_o`  out  XLEN  extended immediate.
- `out_tag_o`  out  TAG_W  tag of the current output beat.

## Operation

- Immediate assembly is combinational on the input side. `s` denotes `inst[31]` replicated to XLEN.
  - NONE: 0.
  - I: s, then `inst[31:20]`.
  - S: s, then `{inst[31:25], inst[11:7]}`.
  - B: s, then `{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}`.
  - U: s, then `{inst[31:12], 12'b0}`. In RV64, bits 63:32 are copies of bit 31.
  - J: s, then `{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}`.
  - Z: zero-extended `inst[19:15]`.
  - SH: zero-extended `inst[25:20]` for XLEN=64, or `inst[24:20]` for XLEN=32.
- Storage is a main output register (M) and a skid register (K). Each holds imm, tag and a valid bit.
- An input transfer occurs when `in_valid_i && in_ready_o`. An output transfer occurs when `out_valid_o && out_ready_i`.
- Per rising edge, when `flush_i` is 0:
  - M empty, or M draining this cycle with K empty: an input transfer loads M.
  - M full and not draining: an input transfer loads K.
  - M draining with K full: K moves to M and K empties. `in_ready_o` is 0, so no input transfer is possible.
- Sequencing: K valid means M valid. Order is strictly FIFO (M, then K, then new beats). A beat is never dropped or duplicated except by flush or reset.
- `in_ready_o = rst & ~K.valid`. It is 0 while reset is asserted.
- `out_valid_o = M.valid`.
- `out_imm_o` and `out_tag_o` are forced to 0 whenever `out_valid_o` is 0.
- `flush_i` = 1: both valid bits clear at the next edge. Any input transfer on the same cycle is discarded. An output transfer on that cycle still counts as completed downstream.
- XLEN outside {32, 64}: elaboration-time error.

## Timing

- Reset (`rst` low): asynchronous. M.valid and K.valid clear immediately, not at a clock edge. `out_valid_o`, `out_imm_o`, `out_tag_o` and `in_ready_o` are all 0. After `rst` rises, `in_ready_o` is 1 and `out_valid_o` is 0.
- Latency: 1 cycle. A beat accepted at edge N is on `out_*` after edge N.
- Throughput: 1 beat per cycle while `out_ready_i` stays high.
- Back-pressure:
  - The first stalled cycle still accepts one beat into K.
  - `in_ready_o` drops on the cycle after K fills.
  - `in_ready_o` comes from registered state only; it has no combinational path from `out_ready_i`.
- Held outputs: while `out_valid_o && !out_ready_i`, `out_imm_o` and `out_tag_o` stay stable.
- Reset mid-stream: all in-flight beats are lost. No partial state survives.

## Test plan

- Reset values: after reset, `out_valid_o`=0, `out_imm_o`=0, `in_ready_o`=1.
- I-type sign extension: XLEN=64, `in_inst_i`=0xFFF00093, fmt=1, tag=0x80000000 -> next cycle `out_imm_o`=0xFFFFFFFFFFFFFFFF, `out_tag_o`=0x80000000.
- B and U formats:
  - inst=0xFE000EE3, fmt=3 -> 0xFFFFFFFFFFFFFFFC.
  - inst=0x800000B7, fmt=4 -> 0xFFFFFFFF80000000 at XLEN=64, and 0x80000000 at XLEN=32.
  - inst=0x03F0D093, fmt=7 -> 0x3F.
- Back-pressure: hold `out_ready_i`=0 and present beats A, B, C on consecutive cycles.
  - A occupies M and B occupies K. `in_ready_o` falls and C is held.
  - Raise `out_ready_i` -> outputs appear as A, B, C on consecutive cycles, each exactly once.
- Flush: with M and K full and a valid input, pulse `flush_i` -> `out_valid_o`=0 and `in_ready_o`=1 next cycle. The input beat is not emitted.
- Asynchronous reset mid-operation: drop `rst` between clock edges while `out_valid_o`=1 -> `out_valid_o` and `out_imm_o` go to 0 before the next edge.
